// File: rtl/sw_max_tracker_pkg.sv
// Shared constants and state encoding for the Smith-Waterman max tracker.
// Imported by sw_lane_argmax8 and sw_max_tracker.
`ifndef SW_MAX_TRACKER_PKG_SV
`define SW_MAX_TRACKER_PKG_SV
package sw_max_tracker_pkg;

  localparam int SW_LANES      = 8;
  localparam int SW_LANE_IDX_W = 3;
  localparam int DRAIN_CYCLES  = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage
`endif

// File: rtl/sw_lane_argmax8.sv
// Combinational 8-lane clamped max with winning lane index.
// Negative scores clamp to 0; the lowest lane wins ties.
module sw_lane_argmax8
  import sw_max_tracker_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [SW_LANES*DATA_WIDTH-1:0] v,
  output logic [DATA_WIDTH-1:0]          vmax,
  output logic [SW_LANE_IDX_W-1:0]       idx
);

  logic [DATA_WIDTH-1:0] lane;

  // Ascending scan with strict compare keeps the lowest index on ties.
  always_comb begin
    lane = '0;
    vmax = '0;
    idx  = '0;
    for (int k = 0; k < SW_LANES; k++) begin
      lane = v[k*DATA_WIDTH +: DATA_WIDTH];
      if (lane[DATA_WIDTH-1])
        lane = '0;
      if (lane[DATA_WIDTH-2:0] > vmax[DATA_WIDTH-2:0]) begin
        vmax = lane;
        idx  = SW_LANE_IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/sw_max_tracker.sv
// Alignment-wide best score tracker with (row, col) of the best cell.
// Position tracking is built only when SW_MAX_POS_EN is defined.
module sw_max_tracker
  import sw_max_tracker_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_WIDTH  = 16,
  parameter int COL_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic                          i_valid,
  input  logic [SW_LANES*DATA_WIDTH-1:0] i_v,
  input  logic [ROW_WIDTH-1:0]          i_row,
  input  logic [COL_WIDTH-1:0]          i_col_base,
  input  logic                          i_last,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [DATA_WIDTH-1:0]         o_max,
  output logic [ROW_WIDTH-1:0]          o_row,
  output logic [COL_WIDTH-1:0]          o_col
);

  state_t                   state;
  logic                     drain_cnt;
  logic                     done_q;
  logic                     accept;
  logic                     start_clr;
  logic [DATA_WIDTH-1:0]    am_max;
  logic [SW_LANE_IDX_W-1:0] am_idx;
  logic                     s1_valid;
  logic [DATA_WIDTH-1:0]    s1_val;
  logic [DATA_WIDTH-1:0]    best;
  logic                     upd;

  assign accept    = i_valid && (state == S_RUN);
  assign start_clr = i_start &&
                     ((state == S_IDLE) || (state == S_DONE));
  assign upd       = s1_valid &&
                     (s1_val[DATA_WIDTH-2:0] > best[DATA_WIDTH-2:0]);

  sw_lane_argmax8 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_argmax (
    .v    (i_v),
    .vmax (am_max),
    .idx  (am_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      drain_cnt <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (i_start)
            state <= S_RUN;
        end
        S_RUN: begin
          if (i_valid && i_last) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 1'(DRAIN_CYCLES - 1)) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 1 captures the lane winner; stage 2 folds it into the best.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      best     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept)
        s1_val <= am_max;
      if (start_clr)
        best <= '0;
      else if (upd)
        best <= s1_val;
    end
  end

`ifdef SW_MAX_POS_EN
  logic [ROW_WIDTH-1:0] s1_row;
  logic [COL_WIDTH-1:0] s1_col;
  logic [ROW_WIDTH-1:0] best_row;
  logic [COL_WIDTH-1:0] best_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_row   <= '0;
      s1_col   <= '0;
      best_row <= '0;
      best_col <= '0;
    end else begin
      if (accept) begin
        s1_row <= i_row;
        s1_col <= i_col_base + COL_WIDTH'(am_idx);
      end
      if (start_clr) begin
        best_row <= '0;
        best_col <= '0;
      end else if (upd) begin
        best_row <= s1_row;
        best_col <= s1_col;
      end
    end
  end

  assign o_row = best_row;
  assign o_col = best_col;
`else
  logic unused_pos;
  assign unused_pos = ^{i_row, i_col_base, am_idx};
  assign o_row      = '0;
  assign o_col      = '0;
`endif

  assign o_busy = (state == S_RUN) || (state == S_DRAIN);
  assign o_done = done_q;
  assign o_max  = best;

endmodule

// File: tb/tb_sw_max_tracker.sv
// Directed self-checking bench for sw_max_tracker.
// Position expectations follow SW_MAX_POS_EN.
module tb_sw_max_tracker;

  localparam int DW = 16;
`ifdef SW_MAX_POS_EN
  localparam bit POS = 1'b1;
`else
  localparam bit POS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_start;
  logic           i_valid;
  logic [8*DW-1:0] i_v;
  logic [15:0]    i_row;
  logic [15:0]    i_col_base;
  logic           i_last;
  logic           o_busy;
  logic           o_done;
  logic [DW-1:0]  o_max;
  logic [15:0]    o_row;
  logic [15:0]    o_col;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sw_max_tracker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_valid    (i_valid),
    .i_v        (i_v),
    .i_row      (i_row),
    .i_col_base (i_col_base),
    .i_last     (i_last),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_max      (o_max),
    .o_row      (o_row),
    .o_col      (o_col)
  );

  function automatic logic [8*DW-1:0] lane(input int k,
                                           input logic [DW-1:0] val);
    logic [8*DW-1:0] r;
    r = '0;
    r[k*DW +: DW] = val;
    return r;
  endfunction

  function automatic logic [15:0] epos(input logic [15:0] p);
    return POS ? p : 16'h0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [8*DW-1:0] v, input logic [15:0] row,
                      input logic [15:0] col, input logic last);
    i_valid    = 1'b1;
    i_v        = v;
    i_row      = row;
    i_col_base = col;
    i_last     = last;
    cyc();
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_v     = '0;
  endtask

  task automatic start();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  // Called in cycle T+1 of the last beat; lat is the cycle offset
  // from the last beat at which o_done was seen, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!o_done && lat < 12) begin
      cyc();
      lat++;
    end
    if (!o_done)
      lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 0; i_valid = 0; i_last = 0;
    i_v = '0; i_row = '0; i_col_base = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if (o_max !== 16'h0) begin
      n_fail++; $display("FAIL reset_max got %h exp 0", o_max);
    end
    n_checks++;
    if ({o_row, o_col} !== 32'h0) begin
      n_fail++; $display("FAIL reset_pos got %h/%h exp 0", o_row, o_col);
    end
    n_checks++;
    if ({o_busy, o_done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ctl got %b%b exp 00", o_busy, o_done);
    end
  endtask

  task automatic test_ignored();
    beat(lane(0, 16'd50), 16'd5, 16'd5, 1'b1);
    cyc(); cyc();
    n_checks++;
    if ({o_max, o_busy, o_done} !== {16'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL idle_beat got max=%0d busy=%b done=%b exp 0/0/0",
               o_max, o_busy, o_done);
    end
    start();
    beat(lane(0, 16'd10), 16'd2, 16'd0, 1'b0);
    start();
    beat(lane(0, 16'd12), 16'd3, 16'd7, 1'b1);
    // restart request in DRAIN must not delay o_done
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    n_checks++;
    if ({o_busy, o_done} !== 2'b10) begin
      n_fail++; $display("FAIL drain_start got %b%b exp 10", o_busy, o_done);
    end
    cyc();
    n_checks++;
    if (o_done !== 1'b1 || o_max !== 16'd12 ||
        o_row !== epos(16'd3) || o_col !== epos(16'd7)) begin
      n_fail++;
      $display("FAIL ignored_res got done=%b %0d r%0d c%0d exp 1 12 r%0d c%0d",
               o_done, o_max, o_row, o_col, epos(16'd3), epos(16'd7));
    end
    beat(lane(0, 16'd99), 16'd8, 16'd8, 1'b1);
    cyc(); cyc();
    n_checks++;
    if (o_max !== 16'd12 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_beat got %0d busy=%b exp 12 busy=0", o_max, o_busy);
    end
  endtask

  task automatic test_basic();
    int lat;
    start();
    beat(lane(0, 16'd5) | lane(1, 16'd9) | lane(2, 16'd3),
         16'd4, 16'd10, 1'b1);
    wait_done(lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL basic_lat got %0d exp 3", lat);
    end
    n_checks++;
    if (o_max !== 16'd9 || o_row !== epos(16'd4) ||
        o_col !== epos(16'd11)) begin
      n_fail++;
      $display("FAIL basic_res got %0d r%0d c%0d exp 9 r%0d c%0d",
               o_max, o_row, o_col, epos(16'd4), epos(16'd11));
    end
    cyc();
    n_checks++;
    if ({o_busy, o_done} !== 2'b00 || o_max !== 16'd9) begin
      n_fail++;
      $display("FAIL basic_hold got %b%b %0d exp 00 9",
               o_busy, o_done, o_max);
    end
  endtask

  task automatic test_ties();
    int lat;
    start();
    beat(lane(2, 16'd7) | lane(6, 16'd7), 16'd1, 16'd0, 1'b0);
    beat(lane(0, 16'd7), 16'd2, 16'd0, 1'b1);
    wait_done(lat);
    n_checks++;
    if (lat !== 3 || o_max !== 16'd7 || o_row !== epos(16'd1) ||
        o_col !== epos(16'd2)) begin
      n_fail++;
      $display("FAIL ties got lat%0d %0d r%0d c%0d exp lat3 7 r%0d c%0d",
               lat, o_max, o_row, o_col, epos(16'd1), epos(16'd2));
    end
  endtask

  task automatic test_negatives();
    int lat;
    logic [8*DW-1:0] v;
    for (int k = 0; k < 8; k++)
      v[k*DW +: DW] = 16'h8005;
    start();
    for (int b = 0; b < 3; b++)
      beat(v, 16'(b + 3), 16'd8, b == 2);
    wait_done(lat);
    n_checks++;
    if (lat !== 3 || o_max !== 16'd0 || o_row !== 16'd0 ||
        o_col !== 16'd0) begin
      n_fail++;
      $display("FAIL negatives got lat%0d %0d r%0d c%0d exp lat3 0 r0 c0",
               lat, o_max, o_row, o_col);
    end
  endtask

  task automatic test_col_wrap();
    int lat;
    start();
    beat(lane(3, 16'd20), 16'd6, 16'hFFFE, 1'b1);
    wait_done(lat);
    n_checks++;
    if (lat !== 3 || o_max !== 16'd20 || o_row !== epos(16'd6) ||
        o_col !== epos(16'h0001)) begin
      n_fail++;
      $display("FAIL col_wrap got lat%0d %0d r%0d c%h exp lat3 20 r%0d c%h",
               lat, o_max, o_row, o_col, epos(16'd6), epos(16'h0001));
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start();
    beat(lane(1, 16'd40), 16'd5, 16'd100, 1'b1);
    wait_done(lat);
    n_checks++;
    if (lat !== 3 || o_max !== 16'd40 || o_col !== epos(16'd101)) begin
      n_fail++;
      $display("FAIL b2b_first got lat%0d %0d c%0d exp lat3 40 c%0d",
               lat, o_max, o_col, epos(16'd101));
    end
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    n_checks++;
    if ({o_busy, o_done} !== 2'b10 || o_max !== 16'd0 ||
        o_col !== 16'd0) begin
      n_fail++;
      $display("FAIL b2b_clear got %b%b %0d c%0d exp 10 0 c0",
               o_busy, o_done, o_max, o_col);
    end
    beat(lane(5, 16'd3), 16'd9, 16'd0, 1'b1);
    wait_done(lat);
    n_checks++;
    if (lat !== 3 || o_max !== 16'd3 || o_row !== epos(16'd9) ||
        o_col !== epos(16'd5)) begin
      n_fail++;
      $display("FAIL b2b_second got lat%0d %0d r%0d c%0d exp lat3 3 r%0d c%0d",
               lat, o_max, o_row, o_col, epos(16'd9), epos(16'd5));
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    start();
    beat(lane(0, 16'd30), 16'd1, 16'd1, 1'b0);
    cyc();
    n_checks++;
    if (o_max !== 16'd30) begin
      n_fail++; $display("FAIL mid_max got %0d exp 30", o_max);
    end
    beat(lane(1, 16'd45), 16'd2, 16'd2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_max, o_row, o_col, o_busy, o_done} !== 50'h0) begin
      n_fail++;
      $display("FAIL mid_async got %0d r%0d c%0d %b%b exp all 0",
               o_max, o_row, o_col, o_busy, o_done);
    end
    cyc();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (o_done || o_busy || o_max != 16'd0)
        seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL mid_drop got activity=1 exp 0");
    end
    start();
    beat(lane(1, 16'd4), 16'd1, 16'd1, 1'b1);
    wait_done(lat);
    n_checks++;
    if (lat !== 3 || o_max !== 16'd4 || o_row !== epos(16'd1) ||
        o_col !== epos(16'd2)) begin
      n_fail++;
      $display("FAIL mid_fresh got lat%0d %0d r%0d c%0d exp lat3 4 r%0d c%0d",
               lat, o_max, o_row, o_col, epos(16'd1), epos(16'd2));
    end
  endtask

  initial begin
    test_reset();
    test_ignored();
    test_basic();
    test_ties();
    test_negatives();
    test_col_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
